// File: rtl/wb_commit_trace.sv
// Buffered commit trace for the WB retirement stream. It feeds a valid/ready trace sink,
// raises a registered almost-full stall request and keeps a sticky overflow flag.
module wb_commit_trace #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AF_MARGIN   = 2,
  parameter bit          FILTER_NOWB = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid_i,
  input  logic [31:0]              wb_pc_i,
  input  logic [3:0]               wb_wen_i,
  input  logic [4:0]               wb_dst_i,
  input  logic [31:0]              wb_result_i,
  input  logic                     trace_ready_i,
  output logic                     trace_valid_o,
  output logic [31:0]              trace_pc_o,
  output logic [3:0]               trace_wen_o,
  output logic [4:0]               trace_wnum_o,
  output logic [31:0]              trace_wdata_o,
  output logic [$clog2(DEPTH):0]   trace_count_o,
  output logic                     trace_stall_req_o,
  output logic                     trace_overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfCnt   = CntW'(DEPTH - AF_MARGIN);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  dst;
    logic [31:0] result;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            stall_q, stall_d;
  logic            ovf_q, ovf_d;

  logic   push_req, full, pop, push_acc, drop;
  entry_t wr_entry, head;

  always_comb begin
    push_req = wb_valid_i & (!FILTER_NOWB | ((|wb_wen_i) & (wb_dst_i != 5'd0)));
    full     = (count_q == FullCnt);
    pop      = trace_valid_o & trace_ready_i;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    push_acc = push_req & (!full | pop);
    drop     = push_req & full & !pop;
    wr_entry = '{pc: wb_pc_i, wen: wb_wen_i, dst: wb_dst_i, result: wb_result_i};
  end

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    if (push_acc) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    stall_d = (count_d >= AfCnt);
    ovf_d   = ovf_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: the pop side never exposes a slot that was not written.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wptr_q] <= wr_entry;
    end
  end

  always_comb begin
    head          = mem_q[rptr_q];
    trace_valid_o = (count_q != '0);
    // Data is forced to zero while empty so reset and idle read as zero.
    trace_pc_o    = trace_valid_o ? head.pc     : 32'd0;
    trace_wen_o   = trace_valid_o ? head.wen    : 4'd0;
    trace_wnum_o  = trace_valid_o ? head.dst    : 5'd0;
    trace_wdata_o = trace_valid_o ? head.result : 32'd0;
    trace_count_o     = count_q;
    trace_stall_req_o = stall_q;
    trace_overflow_o  = ovf_q;
  end

  a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= FullCnt);

  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
    (trace_valid_o && !trace_ready_i) |=>
      (trace_valid_o && $stable({trace_pc_o, trace_wen_o, trace_wnum_o, trace_wdata_o})));

  a_ovf_sticky : assert property (@(posedge clk) disable iff (rst)
    trace_overflow_o |=> trace_overflow_o);

endmodule

// File: tb/tb_wb_commit_trace.sv
// Scoreboard bench for wb_commit_trace: the expected entries queue up as pushes are driven.
// The head entry, occupancy and flags are compared every cycle.
module tb_wb_commit_trace;

  localparam int unsigned Depth    = 8;
  localparam int unsigned AfMargin = 2;

  typedef logic [72:0] ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [3:0]  wb_wen = '0;
  logic [4:0]  wb_dst = '0;
  logic [31:0] wb_result = '0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [3:0]  trace_wen;
  logic [4:0]  trace_wnum;
  logic [31:0] trace_wdata;
  logic [3:0]  trace_count;
  logic        trace_stall;
  logic        trace_ovf;

  // Unfiltered instance used only for the record-all check; its sink never accepts.
  logic        all_ready = 1'b0;
  logic        all_valid;
  logic [31:0] all_pc;
  logic [3:0]  all_wen;
  logic [4:0]  all_wnum;
  logic [31:0] all_wdata;
  logic [3:0]  all_count;
  logic        all_stall;
  logic        all_ovf;

  always #5 clk = ~clk;

  wb_commit_trace #(.DEPTH(Depth), .AF_MARGIN(AfMargin), .FILTER_NOWB(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .wb_valid_i(wb_valid), .wb_pc_i(wb_pc), .wb_wen_i(wb_wen), .wb_dst_i(wb_dst),
    .wb_result_i(wb_result), .trace_ready_i(trace_ready),
    .trace_valid_o(trace_valid), .trace_pc_o(trace_pc), .trace_wen_o(trace_wen),
    .trace_wnum_o(trace_wnum), .trace_wdata_o(trace_wdata), .trace_count_o(trace_count),
    .trace_stall_req_o(trace_stall), .trace_overflow_o(trace_ovf)
  );

  wb_commit_trace #(.DEPTH(Depth), .AF_MARGIN(AfMargin), .FILTER_NOWB(1'b0)) u_dut_all (
    .clk(clk), .rst(rst),
    .wb_valid_i(wb_valid), .wb_pc_i(wb_pc), .wb_wen_i(wb_wen), .wb_dst_i(wb_dst),
    .wb_result_i(wb_result), .trace_ready_i(all_ready),
    .trace_valid_o(all_valid), .trace_pc_o(all_pc), .trace_wen_o(all_wen),
    .trace_wnum_o(all_wnum), .trace_wdata_o(all_wdata), .trace_count_o(all_count),
    .trace_stall_req_o(all_stall), .trace_overflow_o(all_ovf)
  );

  int   n_vec = 0;
  int   n_err = 0;
  ent_t sb[$];
  logic ovf_m   = 1'b0;
  logic stall_m = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb_valid = 1'b0;
    trace_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    ovf_m   = 1'b0;
    stall_m = 1'b0;
    check_eq("rst_data", 128'({trace_pc, trace_wen, trace_wnum, trace_wdata}), 128'(0));
  endtask

  // One cycle: drive inputs, check outputs on the falling edge, advance the model.
  task automatic tick(input logic v, input logic [31:0] pc, input logic [3:0] wen,
                      input logic [4:0] dst, input logic [31:0] res, input logic rdy);
    logic preq, full, pop;
    wb_valid = v; wb_pc = pc; wb_wen = wen; wb_dst = dst; wb_result = res;
    trace_ready = rdy;
    @(negedge clk);
    check_eq("valid", 128'(trace_valid), 128'(sb.size() != 0));
    check_eq("count", 128'(trace_count), 128'(sb.size()));
    check_eq("stall", 128'(trace_stall), 128'(stall_m));
    check_eq("ovf", 128'(trace_ovf), 128'(ovf_m));
    if (sb.size() != 0) begin
      check_eq("head", 128'({trace_pc, trace_wen, trace_wnum, trace_wdata}), 128'(sb[0]));
    end
    preq = v && (wen != 4'd0) && (dst != 5'd0);
    full = (sb.size() == Depth);
    pop  = rdy && (sb.size() != 0);
    if (pop) void'(sb.pop_front());
    if (preq && (!full || pop)) sb.push_back({pc, wen, dst, res});
    else if (preq) ovf_m = 1'b1;
    stall_m = (sb.size() >= Depth - AfMargin);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, 32'd0, 4'd0, 5'd0, 32'd0, rdy);
  endtask

  initial begin
    do_reset();
    idle(1'b0);

    // Push/latency and hold while the sink stalls.
    tick(1'b1, 32'hBFC0_0000, 4'hF, 5'd3, 32'h1234_5678, 1'b0);
    check_eq("lat_pc", 128'(trace_pc), 128'(32'hBFC0_0000));
    for (int i = 0; i < 5; i++) idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    check_eq("lat_drain", 128'(trace_count), 128'(0));

    // Filter: no-write and x0 retirements are dropped unless recording all.
    do_reset();
    tick(1'b1, 32'h2000, 4'h0, 5'd5, 32'hAAAA_0001, 1'b0);
    tick(1'b1, 32'h2004, 4'hF, 5'd0, 32'hAAAA_0002, 1'b0);
    idle(1'b0);
    check_eq("flt_count", 128'(trace_count), 128'(0));
    check_eq("nowb_count", 128'(all_count), 128'(2));
    check_eq("nowb_pc", 128'(all_pc), 128'(32'h2000));

    // Fill past capacity: stall, saturation, drop, sticky overflow.
    do_reset();
    for (int i = 0; i < 9; i++) tick(1'b1, 32'h3000 + 32'(4 * i), 4'hF, 5'(i + 1), 32'(i), 1'b0);
    idle(1'b0);
    check_eq("fill_count", 128'(trace_count), 128'(8));
    check_eq("fill_ovf", 128'(trace_ovf), 128'(1));
    for (int i = 0; i < 9; i++) idle(1'b1);
    check_eq("drain_ovf", 128'(trace_ovf), 128'(1));

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, 32'h4000 + 32'(4 * i), 4'h3, 5'd7, 32'(100 + i), 1'b0);
    tick(1'b1, 32'h4FFC, 4'hC, 5'd9, 32'hDEAD_BEEF, 1'b1);
    check_eq("fpp_count", 128'(trace_count), 128'(8));
    check_eq("fpp_ovf", 128'(trace_ovf), 128'(0));
    for (int i = 0; i < 9; i++) idle(1'b1);

    // Wrap-around with a toggling sink.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 32'h1000 + 32'(4 * i), 4'hF, 5'((i % 31) + 1), 32'h5A00_0000 + 32'(i),
           (i % 2) == 0);
    end
    for (int i = 0; i < 30 && sb.size() != 0; i++) idle(1'b1);
    idle(1'b0);
    check_eq("wrap_empty", 128'(trace_count), 128'(0));

    // Reset mid-operation discards everything.
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 32'h6000 + 32'(4 * i), 4'h1, 5'd2, 32'(i), 1'b0);
    check_eq("mid_count", 128'(trace_count), 128'(5));
    do_reset();
    idle(1'b0);
    tick(1'b1, 32'hCAFE_0000, 4'h6, 5'd11, 32'h0BAD_F00D, 1'b0);
    idle(1'b0);
    check_eq("mid_first", 128'(trace_pc), 128'(32'hCAFE_0000));
    idle(1'b1);
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
